// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low/full speed bit-level transmitter.
// Line states, FSM encoding, SYNC/stuffing constants and the NRZI step helper.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10
  } d_port_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  // NRZI: a 0 toggles the line between J and K, a 1 holds it.
  function automatic d_port_t nrzi_step(input d_port_t level, input logic tx_bit);
    if (tx_bit) return level;
    return (level == J) ? K : J;
  endfunction

endpackage

// File: rtl/usb_tx_if.sv
// SIE-side byte handshake plus line-state outputs of the USB transmitter.
// The transmitter takes the slave modport; the SIE/driver side takes master.
interface usb_tx_if;
  import usb_tx_pkg::*;

  logic [7:0] data;
  logic       valid;
  logic       ready;
  d_port_t    d;
  logic       oe;
  logic       active;

  modport master (
    output data,
    output valid,
    input  ready,
    input  d,
    input  oe,
    input  active
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    output d,
    output oe,
    output active
  );

endinterface

// File: rtl/usb_tx_nrzi.sv
// Bit-stuff run counter and NRZI line-level register of the USB transmitter.
// stuff_req is high when the bits already on the line end in a run of six 1s.
module usb_tx_nrzi
  import usb_tx_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    clk_en,
  input  logic    tx_bit,
  input  logic    bit_valid,
  input  logic    clear,
  output d_port_t level,
  output logic    stuff_req
);

  logic [2:0] ones_cnt;

  // NOTE: state registers are written only with <= so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level    <= J;
      ones_cnt <= '0;
    end else if (clk_en) begin
      if (clear) begin
        level    <= J;
        ones_cnt <= '0;
      end else if (bit_valid) begin
        level    <= nrzi_step(level, tx_bit);
        ones_cnt <= tx_bit ? ones_cnt + 3'd1 : 3'd0;
      end
    end
  end

  assign stuff_req = (ones_cnt == STUFF_LIMIT);

endmodule

// File: rtl/usb_tx.sv
// USB low/full speed bit-level transmitter: SYNC, bit-stuffed NRZI data, EOP.
// Optional low-speed keep-alive generation is enabled by USB_TX_KEEPALIVE_EN.
module usb_tx
  import usb_tx_pkg::*;
#(
  parameter int EOP_SE0_BITS = 2
) (
  input logic clk,
  input logic reset_n,
  input logic clk_en,
`ifdef USB_TX_KEEPALIVE_EN
  input logic keepalive,
`endif
  usb_tx_if.slave bus
);

  localparam logic [1:0] EOP_LAST = 2'(EOP_SE0_BITS);

  tx_state_t  state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [1:0] se0_cnt, se0_cnt_n;
  logic       ready_q;
  logic       capture;
  logic       tx_bit;
  logic       bit_valid;
  logic       nrzi_clear;
  d_port_t    line_level;
  logic       stuff_req;

`ifdef USB_TX_KEEPALIVE_EN
  logic ka_req;
  logic ka_mode, ka_mode_n;
  logic ka_serve;
`endif

  usb_tx_nrzi u_nrzi (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .tx_bit    (tx_bit),
    .bit_valid (bit_valid),
    .clear     (nrzi_clear),
    .level     (line_level),
    .stuff_req (stuff_req)
  );

  // Each tick decides the bit that will be on the line after the edge;
  // state names describe what the line currently shows.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    se0_cnt_n  = se0_cnt;
    capture    = 1'b0;
    tx_bit     = 1'b0;
    bit_valid  = 1'b0;
    nrzi_clear = 1'b0;
`ifdef USB_TX_KEEPALIVE_EN
    ka_mode_n  = ka_mode;
    ka_serve   = 1'b0;
`endif

    unique case (state)
      ST_IDLE: begin
        if (bus.valid) begin
          capture   = 1'b1;
          shreg_n   = bus.data;
          tx_bit    = SYNC_PATTERN[0];
          bit_valid = 1'b1;
          bit_cnt_n = 3'd1;
          state_n   = ST_SYNC;
        end
`ifdef USB_TX_KEEPALIVE_EN
        else if (ka_req) begin
          ka_serve  = 1'b1;
          ka_mode_n = 1'b1;
          se0_cnt_n = 2'd1;
          state_n   = ST_EOP_SE0;
        end
`endif
      end

      ST_SYNC: begin
        bit_valid = 1'b1;
        if (bit_cnt == 3'd0) begin
          // All eight SYNC bits are out; the first data bit follows directly.
          tx_bit    = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_cnt_n = 3'd1;
          state_n   = ST_DATA;
        end else begin
          tx_bit    = SYNC_PATTERN[bit_cnt];
          bit_cnt_n = bit_cnt + 3'd1;
        end
      end

      ST_DATA, ST_STUFF: begin
        if (stuff_req) begin
          tx_bit    = 1'b0;
          bit_valid = 1'b1;
          state_n   = ST_STUFF;
        end else if (bit_cnt != 3'd0) begin
          tx_bit    = shreg[0];
          bit_valid = 1'b1;
          shreg_n   = {1'b0, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          state_n   = ST_DATA;
        end else if (bus.valid) begin
          // Byte boundary with more data: the next byte starts without a gap.
          capture   = 1'b1;
          tx_bit    = bus.data[0];
          bit_valid = 1'b1;
          shreg_n   = {1'b0, bus.data[7:1]};
          bit_cnt_n = 3'd1;
          state_n   = ST_DATA;
        end else begin
          se0_cnt_n = 2'd1;
          state_n   = ST_EOP_SE0;
        end
      end

      ST_EOP_SE0: begin
        if (se0_cnt == EOP_LAST) begin
          state_n = ST_EOP_J;
        end else begin
          se0_cnt_n = se0_cnt + 2'd1;
        end
      end

      ST_EOP_J: begin
        nrzi_clear = 1'b1;
`ifdef USB_TX_KEEPALIVE_EN
        ka_mode_n  = 1'b0;
`endif
        state_n    = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: the shift register is reset with the control state so a packet aborted
  // by reset leaves no stale byte behind.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      se0_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= clk_en & capture;
      if (clk_en) begin
        state   <= state_n;
        shreg   <= shreg_n;
        bit_cnt <= bit_cnt_n;
        se0_cnt <= se0_cnt_n;
      end
    end
  end

`ifdef USB_TX_KEEPALIVE_EN
  // The request is latched on any clk; it is only consumed on a serving tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ka_req  <= 1'b0;
      ka_mode <= 1'b0;
    end else begin
      ka_req <= keepalive | (ka_req & ~(clk_en & ka_serve));
      if (clk_en) ka_mode <= ka_mode_n;
    end
  end
`endif

  always_comb begin
    unique case (state)
      ST_SYNC, ST_DATA, ST_STUFF: bus.d = line_level;
      ST_EOP_SE0:                 bus.d = SE0;
      default:                    bus.d = J;
    endcase
    bus.oe     = (state != ST_IDLE);
`ifdef USB_TX_KEEPALIVE_EN
    bus.active = (state != ST_IDLE) && !ka_mode;
`else
    bus.active = (state != ST_IDLE);
`endif
  end

  assign bus.ready = ready_q;

endmodule
